// File: rtl/uart_packet_decoder_pkg.sv
// Shared definitions for the UART packet decoder: FSM state encoding,
// error-code values, default frame marker and a counter-width helper.
// Ports: none (package).
package uart_packet_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CSUM    = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_LEN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CSUM    = 2'd3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Bits needed to hold any value in 0..max_val (never less than one).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_pkt_timeout.sv
// Inter-byte idle timer for the packet decoder.
// Latency: expired is combinational, asserted during the TIMEOUT_CYCLES-th enabled cycle since the last clear.
// Backpressure: none; the owner gates enable so that stalled cycles are not counted.
// Ports: clk, reset (async, active low), clear (restart count), enable (count this cycle), expired.
module uart_pkt_timeout
   import uart_packet_decoder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 33_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // A clear in the same cycle wins: an accepted byte is never reported as a timeout.
   assign expired = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear || expired) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_packet_decoder.sv
// Extracts SYNC, LEN, payload[, CSUM] frames from a UART receiver byte stream.
// Latency: payload byte accepted in cycle N is presented in N+1; done/err pulse in the cycle after the terminating byte.
// Backpressure: single output register; payload input stalls only while that register is full and not draining.
// Ports: clk, reset (async, active low); in_data/in_valid/in_ready from the receiver; out_data/out_valid/
//        out_ready/out_last payload stream; pkt_done/pkt_err pulses; err_code 1=bad LEN, 2=timeout, 3=checksum.
// Build option: define UART_PKT_CHECKSUM_EN to require and verify a trailing checksum byte.
module uart_packet_decoder
   import uart_packet_decoder_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ     = 33_000_000,
   parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int unsigned MAX_LEN        = 64,
   parameter int unsigned TIMEOUT_CYCLES = 33_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [1:0] err_code
);

   // CLOCK_FREQ only documents what TIMEOUT_CYCLES means in wall-clock time.
   if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1 || CLOCK_FREQ < 1) begin : g_param_check
      $error("uart_packet_decoder: MAX_LEN must be 1..255, TIMEOUT_CYCLES and CLOCK_FREQ nonzero");
   end

   localparam int unsigned LEN_W = cnt_width(MAX_LEN);

   state_t           state, next_state;
   logic [LEN_W-1:0] remaining;
   logic             accept, len_bad, last_byte;
   logic             to_enable, expired;
   logic             set_done, set_err;
   logic [1:0]       next_code;

   // Only the payload phase can be backpressured; every other phase always takes a byte.
   assign in_ready  = (state == ST_PAYLOAD) ? (!out_valid || out_ready) : 1'b1;
   assign accept    = in_valid && in_ready;
   assign len_bad   = (in_data == 8'd0) || (32'(in_data) > MAX_LEN);
   assign last_byte = (remaining == LEN_W'(1));

   // Every entry into LEN/PAYLOAD/CSUM happens on an accepted byte, so clearing on
   // accept also covers the clear-on-entry rule. Stalled cycles are frozen.
   assign to_enable = (state != ST_IDLE) && !(in_valid && !in_ready);

   uart_pkt_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .enable (to_enable),
      .expired(expired)
   );

`ifdef UART_PKT_CHECKSUM_EN
   logic [7:0] sum;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      set_done   = 1'b0;
      set_err    = 1'b0;
      next_code  = err_code;
      case (state)
         ST_IDLE: begin
            if (accept && in_data == SYNC_BYTE) next_state = ST_LEN;
         end
         ST_LEN: begin
            if (accept) begin
               if (len_bad) begin
                  next_state = ST_IDLE;
                  set_err    = 1'b1;
                  next_code  = ERR_BAD_LEN;
               end else begin
                  next_state = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (accept && last_byte) begin
`ifdef UART_PKT_CHECKSUM_EN
               next_state = ST_CSUM;
`else
               next_state = ST_IDLE;
               set_done   = 1'b1;
`endif
            end
         end
`ifdef UART_PKT_CHECKSUM_EN
         ST_CSUM: begin
            if (accept) begin
               next_state = ST_IDLE;
               if (in_data == sum) begin
                  set_done = 1'b1;
               end else begin
                  set_err   = 1'b1;
                  next_code = ERR_CSUM;
               end
            end
         end
`endif
         default: next_state = ST_IDLE;
      endcase
      // expired excludes an accepted byte, so it never competes with the cases above.
      if (expired) begin
         next_state = ST_IDLE;
         set_done   = 1'b0;
         set_err    = 1'b1;
         next_code  = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         pkt_done  <= 1'b0;
         pkt_err   <= 1'b0;
         err_code  <= ERR_NONE;
         remaining <= '0;
      end else begin
         pkt_done <= set_done;
         pkt_err  <= set_err;
         err_code <= next_code;
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (state == ST_PAYLOAD && accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= last_byte;
            remaining <= remaining - LEN_W'(1);
         end else if (state == ST_LEN && accept && !len_bad) begin
            remaining <= LEN_W'(in_data);
         end
         // An aborted frame has no final byte; a payload byte still waiting
         // in the register goes out as ordinary data.
         if (expired) out_last <= 1'b0;
      end
   end

`ifdef UART_PKT_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum <= 8'd0;
      end else if (accept) begin
         if (state == ST_LEN) sum <= in_data;
         else if (state == ST_PAYLOAD) sum <= sum + in_data;
      end
   end
`endif

endmodule
